trap_unit: RTL and testbench
============================

TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instr_valid  input  1  decoded instruction in the execute stage is valid this cycle.
REQ-005 scause_in  input  8  cause from the control decoder; nop=8'h00, illegal=8'h02, ecall=8'h0B.
REQ-006 is_mret  input  1  the decoder flagged mret.
REQ-007 pc_in  input  32  PC of the current instruction.
REQ-008 instr_in  input  32  raw instruction word.
REQ-009 csr_we  input  1  CSR write strobe.
REQ-010 csr_addr  input  12  CSR address for both read and write.
REQ-011 csr_wdata  input  32  CSR write data.
REQ-012 csr_rdata  output  32  combinational read of csr_addr; unimplemented addresses read 0.
REQ-013 stall  output  1  freezes the PC and pipeline while the FSM is not in IDLE.
REQ-014 redirect_valid  output  1  one-cycle pulse; the PC SHALL load redirect_pc.
REQ-015 redirect_pc  output  32  trap vector or return address.

Function
REQ-016 CSRs SHALL be: mstatus 0x300 (MIE bit3, MPIE bit7, all other bits read 0), mtvec 0x305, mepc 0x341, mcause 0x342, and mtval 0x343 (macro-gated).
REQ-017 Bits [1:0] of mtvec and mepc SHALL always read 0, with the written values ignored.
REQ-018 FSM states SHALL be IDLE, SAVE, TVEC and RET.
REQ-019 A trap is taken in IDLE when instr_valid=1 and scause_in!=8'h00; IDLE then moves to SAVE.
REQ-020 In SAVE: mepc<=pc_in latched at acceptance, mcause<={24'h0,scause_in}, MPIE<=MIE, MIE<=0; SAVE then moves to TVEC.
REQ-021 In TVEC: redirect_valid=1 and redirect_pc={mtvec[31:2],2'b00}; TVEC then moves to IDLE.
REQ-022 Trap latency: trap accepted in cycle N gives redirect_valid high in cycle N+2, for exactly one cycle.
REQ-023 mret is taken in IDLE when instr_valid=1, is_mret=1 and no trap is pending; IDLE then moves to RET.
REQ-024 In RET: redirect_valid=1, redirect_pc=mepc, MIE<=MPIE, MPIE<=1; RET then moves to IDLE, giving latency N+1.
REQ-025 stall SHALL be 1 in SAVE, TVEC and RET, and 0 in IDLE.
REQ-026 Inputs presented while stall=1 SHALL be ignored.
REQ-027 A trap has priority over mret and over csr_we in the same cycle; the CSR write is dropped.
REQ-028 csr_we is honoured only in IDLE with no trap or mret accepted; the write lands at the next edge.
REQ-029 pc_in and scause_in SHALL be captured on acceptance, so later changes during SAVE do not affect mepc or mcause.
REQ-030 A trap accepted on the same edge that a CSR write would target mepc or mcause SHALL leave the trap values in those registers.

Reset
REQ-031 On rst: state=IDLE, mstatus=0, mtvec=0, mepc=0, mcause=0, mtval=0.
REQ-032 On rst: stall=0, redirect_valid=0, redirect_pc=0.
REQ-033 rst asserted in SAVE, TVEC or RET SHALL abort the operation with no redirect pulse afterwards.

Configuration
REQ-034 With macro TRAP_MTVAL_EN defined: mtval at 0x343 is implemented.
REQ-035 With TRAP_MTVAL_EN defined, SAVE loads mtval<=instr_in for illegal (8'h02) and mtval<=0 for ecall.
REQ-036 Without TRAP_MTVAL_EN: no mtval register is built, 0x343 reads 0, and writes to it are ignored.

Verification
REQ-037 Reset then ecall: mtvec=0x0000_0100, pc_in=0x0000_0040, scause_in=8'h0B in cycle N -> redirect_valid at N+2, redirect_pc=0x100, mepc=0x40, mcause=0x0B, MIE=0.
REQ-038 mret after that trap with MPIE=1 -> redirect_valid at N+1, redirect_pc=0x40, MIE=1, MPIE=1.
REQ-039 Illegal trap with instr_in=0xFFFF_FFFF, macro on -> mcause=0x02, mtval=0xFFFF_FFFF; macro off -> read 0x343 returns 0.
REQ-040 Trap, mret and csr_we to mepc all in the same cycle -> trap wins, mepc=pc_in, no RET entry.
REQ-041 Write mtvec=0x0000_0203 -> reads 0x0000_0200; a subsequent trap redirects to 0x200.
REQ-042 rst pulsed during SAVE -> no redirect_valid pulse, all CSRs 0, stall=0 at the next cycle.

Source files
------------

// File: rtl/trap_unit.sv
// -----------------------------------------------------------------------------
// trap_unit
//
// Machine-mode trap and return sequencer with its CSR file. A non-zero cause on
// a valid instruction saves the PC and cause, clears MIE, and redirects fetch
// to mtvec. An mret restores MIE and redirects to mepc. While a sequence is in
// flight, stall holds the pipeline and all inputs are ignored.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   instr_valid     execute-stage instruction is valid this cycle
//   scause_in[7:0]  decoded cause (0x00 none, 0x02 illegal, 0x0B ecall)
//   is_mret         decoder flagged mret
//   pc_in[31:0]     PC of the current instruction
//   instr_in[31:0]  raw instruction word (feeds mtval)
//   csr_we          CSR write strobe
//   csr_addr[11:0]  CSR address for read and write
//   csr_wdata[31:0] CSR write data
//   csr_rdata[31:0] combinational read of csr_addr, 0 for unimplemented CSRs
//   stall           high whenever the sequencer is not idle
//   redirect_valid  one-cycle pulse: fetch must load redirect_pc
//   redirect_pc     trap vector or return address
//
// Configuration
//   TRAP_MTVAL_EN   when defined, builds mtval (0x343); otherwise 0x343 reads
//                   0 and ignores writes.
// -----------------------------------------------------------------------------
module trap_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [7:0]  scause_in,
    input  logic        is_mret,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef TRAP_MTVAL_EN
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [7:0]  CAUSE_ILLEGAL = 8'h02;
`endif
    localparam logic [7:0]  CAUSE_NONE   = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        TVEC = 2'd2,
        RET  = 2'd3
    } state_t;

    state_t state, next_state;

    // CSR state. mtvec and mepc keep only bits [31:2]; the low bits read 0.
    logic        mie;
    logic        mpie;
    logic [29:0] mtvec_base;
    logic [29:0] mepc_word;
    logic [31:0] mcause;

    // Values captured at trap acceptance so that input changes during SAVE
    // cannot corrupt what is written into the CSRs.
    logic [29:0] cap_pc;
    logic [7:0]  cap_cause;

`ifdef TRAP_MTVAL_EN
    logic [31:0] mtval;
    logic [31:0] cap_instr;
`else
    logic        unused_instr;
    assign unused_instr = ^instr_in;
`endif

    logic trap_take;
    logic mret_take;
    logic csr_take;

    // Acceptance decode: trap beats mret, and either beats a CSR write.
    assign trap_take = (state == IDLE) && instr_valid && (scause_in != CAUSE_NONE);
    assign mret_take = (state == IDLE) && instr_valid && is_mret && !trap_take;
    assign csr_take  = (state == IDLE) && csr_we && !trap_take && !mret_take;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state     = state;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        unique case (state)
            IDLE: begin
                stall = 1'b0;
                if (trap_take)      next_state = SAVE;
                else if (mret_take) next_state = RET;
            end
            SAVE: next_state = TVEC;
            TVEC: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mtvec_base, 2'b00};
                next_state     = IDLE;
            end
            RET: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mepc_word, 2'b00};
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        csr_rdata = 32'h0;
        unique case (csr_addr)
            ADDR_MSTATUS: csr_rdata = {24'h0, mpie, 3'b000, mie, 3'b000};
            ADDR_MTVEC:   csr_rdata = {mtvec_base, 2'b00};
            ADDR_MEPC:    csr_rdata = {mepc_word, 2'b00};
            ADDR_MCAUSE:  csr_rdata = mcause;
`ifdef TRAP_MTVAL_EN
            ADDR_MTVAL:   csr_rdata = mtval;
`endif
            default:      csr_rdata = 32'h0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // All registers here are few and architecturally visible, so all are reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mie        <= 1'b0;
            mpie       <= 1'b0;
            mtvec_base <= '0;
            mepc_word  <= '0;
            mcause     <= '0;
            cap_pc     <= '0;
            cap_cause  <= '0;
`ifdef TRAP_MTVAL_EN
            mtval      <= '0;
            cap_instr  <= '0;
`endif
        end else begin
            state <= next_state;

            if (trap_take) begin
                cap_pc    <= pc_in[31:2];
                cap_cause <= scause_in;
`ifdef TRAP_MTVAL_EN
                cap_instr <= instr_in;
`endif
            end

            // CSR writes only land from IDLE; SAVE/RET updates below only
            // happen outside IDLE, so the two never collide.
            if (csr_take) begin
                unique case (csr_addr)
                    ADDR_MSTATUS: begin
                        mie  <= csr_wdata[3];
                        mpie <= csr_wdata[7];
                    end
                    ADDR_MTVEC:  mtvec_base <= csr_wdata[31:2];
                    ADDR_MEPC:   mepc_word  <= csr_wdata[31:2];
                    ADDR_MCAUSE: mcause     <= csr_wdata;
`ifdef TRAP_MTVAL_EN
                    ADDR_MTVAL:  mtval      <= csr_wdata;
`endif
                    default: ;
                endcase
            end

            if (state == SAVE) begin
                mepc_word <= cap_pc;
                mcause    <= {24'h0, cap_cause};
                mpie      <= mie;
                mie       <= 1'b0;
`ifdef TRAP_MTVAL_EN
                mtval     <= (cap_cause == CAUSE_ILLEGAL) ? cap_instr : 32'h0;
`endif
            end

            if (state == RET) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_trap_unit
//
// Self-checking bench for trap_unit. Each trap/mret drive pushes the expected
// redirect (cycle and target) into a scoreboard; a negedge monitor pops and
// compares on every redirect_valid pulse. CSR contents are checked by direct
// reads while idle. Define TRAP_MTVAL_EN for both bench and RTL to cover mtval.
// -----------------------------------------------------------------------------
module tb_trap_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [7:0]  scause_in;
    logic        is_mret;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    trap_unit dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .scause_in      (scause_in),
        .is_mret        (is_mret),
        .pc_in          (pc_in),
        .instr_in       (instr_in),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && redirect_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("redirect_cycle", cyc, e.cyc);
                check("redirect_pc", redirect_pc, e.pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_valid = 1'b0;
        scause_in   = 8'h00;
        is_mret     = 1'b0;
        pc_in       = 32'h0;
        instr_in    = 32'h0;
        csr_we      = 1'b0;
        csr_addr    = 12'h000;
        csr_wdata   = 32'h0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        step();
        csr_we    = 1'b0;
    endtask

    // Accept a trap, then throw junk at every input during SAVE to show it is
    // ignored (pc/cause capture, blocked mret, blocked CSR write).
    task automatic do_trap(input logic [7:0] cause, input logic [31:0] pc,
                           input logic [31:0] instr, input logic [31:0] target);
        instr_valid = 1'b1;
        scause_in   = cause;
        pc_in       = pc;
        instr_in    = instr;
        sb.push_back('{cyc: cyc + 2, pc: target});
        step();
        check("stall_in_save", {31'h0, stall}, 32'h1);
        scause_in = 8'h0B;
        pc_in     = 32'hDEAD_BEE0;
        instr_in  = 32'h1234_5678;
        is_mret   = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = A_MTVEC;
        csr_wdata = 32'hFFFF_FFF0;
        step();
        clear_inputs();
        step();
        check("stall_idle_after_trap", {31'h0, stall}, 32'h0);
    endtask

    task automatic do_mret(input logic [31:0] target);
        instr_valid = 1'b1;
        is_mret     = 1'b1;
        sb.push_back('{cyc: cyc + 1, pc: target});
        step();
        check("stall_in_ret", {31'h0, stall}, 32'h1);
        clear_inputs();
        step();
        check("stall_idle_after_ret", {31'h0, stall}, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst = 1'b1;
        #2;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_check("rst_mstatus", A_MSTATUS, 32'h0);
        read_check("rst_mtvec", A_MTVEC, 32'h0);
        read_check("rst_mepc", A_MEPC, 32'h0);
        read_check("rst_mcause", A_MCAUSE, 32'h0);
        read_check("rst_mtval", A_MTVAL, 32'h0);
        read_check("unimpl_csr", 12'h7C0, 32'h0);

        // ecall with MIE set, so MPIE becomes 1.
        step();
        csr_write(A_MTVEC, 32'h0000_0100);
        csr_write(A_MSTATUS, 32'hFFFF_FFFF);
        read_check("mstatus_mask", A_MSTATUS, 32'h0000_0088);
        do_trap(8'h0B, 32'h0000_0040, 32'h0, 32'h0000_0100);
        read_check("ecall_mepc", A_MEPC, 32'h0000_0040);
        read_check("ecall_mcause", A_MCAUSE, 32'h0000_000B);
        read_check("ecall_mstatus", A_MSTATUS, 32'h0000_0080);
        read_check("mtvec_not_written_in_stall", A_MTVEC, 32'h0000_0100);
`ifdef TRAP_MTVAL_EN
        read_check("ecall_mtval", A_MTVAL, 32'h0);
`endif

        // mret back to the trapping PC.
        do_mret(32'h0000_0040);
        read_check("mret_mstatus", A_MSTATUS, 32'h0000_0088);

        // Illegal instruction.
        do_trap(8'h02, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0000_0100);
        read_check("illegal_mcause", A_MCAUSE, 32'h0000_0002);
        read_check("illegal_mepc", A_MEPC, 32'h0000_0080);
`ifdef TRAP_MTVAL_EN
        read_check("illegal_mtval", A_MTVAL, 32'hFFFF_FFFF);
        csr_write(A_MTVAL, 32'h0000_5555);
        read_check("mtval_write", A_MTVAL, 32'h0000_5555);
`else
        read_check("illegal_mtval_absent", A_MTVAL, 32'h0);
        csr_write(A_MTVAL, 32'h0000_5555);
        read_check("mtval_write_ignored", A_MTVAL, 32'h0);
`endif

        // Trap, mret and a CSR write to mepc all in one cycle: trap wins.
        csr_we    = 1'b1;
        csr_addr  = A_MEPC;
        csr_wdata = 32'h0000_1234;
        is_mret   = 1'b1;
        do_trap(8'h0B, 32'h0000_00C0, 32'h0, 32'h0000_0100);
        read_check("collide_mepc", A_MEPC, 32'h0000_00C0);
        read_check("collide_mcause", A_MCAUSE, 32'h0000_000B);

        // Low bits of mtvec/mepc are hardwired to zero.
        csr_write(A_MTVEC, 32'h0000_0203);
        read_check("mtvec_low_bits", A_MTVEC, 32'h0000_0200);
        csr_write(A_MEPC, 32'h0000_0047);
        read_check("mepc_low_bits", A_MEPC, 32'h0000_0044);
        csr_write(A_MCAUSE, 32'hA5A5_0001);
        read_check("mcause_write", A_MCAUSE, 32'hA5A5_0001);
        do_trap(8'h0B, 32'h0000_0300, 32'h0, 32'h0000_0200);
        read_check("vec200_mepc", A_MEPC, 32'h0000_0300);

        // Reset pulsed during SAVE aborts with no redirect.
        instr_valid = 1'b1;
        scause_in   = 8'h0B;
        pc_in       = 32'h0000_0400;
        step();
        check("stall_before_abort", {31'h0, stall}, 32'h1);
        clear_inputs();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
        check("abort_stall", {31'h0, stall}, 32'h0);
        step();
        step();
        check("abort_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        read_check("abort_mstatus", A_MSTATUS, 32'h0);
        read_check("abort_mtvec", A_MTVEC, 32'h0);
        read_check("abort_mepc", A_MEPC, 32'h0);
        read_check("abort_mcause", A_MCAUSE, 32'h0);
        read_check("abort_mtval", A_MTVAL, 32'h0);

        step();
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
